// File: rtl/bcm_update_scheduler.sv
// bcm_update_scheduler
// Shares one BCM/triplet weight-update engine across NUM_SYN synapses.
// Pre events (per synapse) and the broadcast post event are latched as
// pending bits; a round-robin arbiter then issues one update transaction
// per synapse to the engine. A drain request reports when all work for a
// timestep has been issued.
// Optional build macro: BCM_SCHED_DROP_CNT_EN enables the saturating
// 16-bit dropped-event counter; without it drop_cnt is tied to zero.
module bcm_update_scheduler #(
    parameter int NUM_SYN = 8,
    parameter int IDX_W   = $clog2(NUM_SYN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_SYN-1:0] pre_spike,
    input  logic               post_spike,
    // Engine handshake: eng_valid rises only in ISSUE and never falls
    // before eng_ready is seen high with it; eng_idx/eng_pre/eng_post are
    // stable for the whole time eng_valid is high. A transfer happens on
    // the clock edge where eng_valid and eng_ready are both 1.
    output logic               eng_valid,
    input  logic               eng_ready,
    output logic [IDX_W-1:0]   eng_idx,
    output logic               eng_pre,
    output logic               eng_post,
    input  logic               step_req,
    output logic               step_done,
    output logic               busy,
    output logic               drop_flag,
    output logic [15:0]        drop_cnt,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SYN-1:0] pend_pre_q, pend_pre_d;
    logic [NUM_SYN-1:0] pend_post_q, pend_post_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   eng_idx_q, eng_idx_d;
    logic               eng_pre_q, eng_pre_d;
    logic               eng_post_q, eng_post_d;
    logic               step_pend_q, step_pend_d;
    logic               busy_q, busy_d;
    logic               drop_flag_q, drop_flag_d;

    logic               handshake;
    logic               any_pend;
    logic [NUM_SYN-1:0] clr_pre;
    logic [NUM_SYN-1:0] clr_post;
    logic               drop_any;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;

    assign handshake = (state_q == ISSUE) && eng_ready;
    assign any_pend  = (|pend_pre_q) || (|pend_post_q);

    // Clear masks: only the bits captured in the snapshot are retired.
    always_comb begin
        clr_pre  = '0;
        clr_post = '0;
        if (handshake) begin
            clr_pre[eng_idx_q]  = eng_pre_q;
            clr_post[eng_idx_q] = eng_post_q;
        end
    end

    // Pending-bit update and drop detection; new events win over a clear.
    always_comb begin
        pend_pre_d  = (pend_pre_q & ~clr_pre) | pre_spike;
        pend_post_d = (pend_post_q & ~clr_post) | {NUM_SYN{post_spike}};
        drop_any    = |((pre_spike & pend_pre_q & ~clr_pre) |
                        ({NUM_SYN{post_spike}} & pend_post_q & ~clr_post));
        drop_flag_d = drop_flag_q | drop_any;
    end

    // Round-robin search: first pending synapse at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_SYN; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_SYN) begin
                cand = cand - NUM_SYN;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_found && (pend_pre_q[cand_idx] || pend_post_q[cand_idx])) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Next-state logic for the issue FSM and the transaction snapshot.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        eng_idx_d  = eng_idx_q;
        eng_pre_d  = eng_pre_q;
        eng_post_d = eng_post_q;
        case (state_q)
            IDLE: begin
                if (en && any_pend) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (grant_found) begin
                    eng_idx_d  = grant_idx;
                    eng_pre_d  = pend_pre_q[grant_idx];
                    eng_post_d = pend_post_q[grant_idx];
                    state_d    = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // en is deliberately ignored here: a raised valid is never withdrawn.
                if (eng_ready) begin
                    rr_ptr_d = (eng_idx_q == IDX_W'(NUM_SYN - 1)) ? '0 : eng_idx_q + IDX_W'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drain tracking and the registered busy indication.
    always_comb begin
        step_done   = step_pend_q && (state_q == IDLE) && !any_pend;
        step_pend_d = step_done ? 1'b0 : (step_pend_q | step_req);
        busy_d      = (|pend_pre_d) || (|pend_post_d) || (state_d != IDLE);
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_pre_q  <= '0;
            pend_post_q <= '0;
            rr_ptr_q    <= '0;
            eng_idx_q   <= '0;
            eng_pre_q   <= 1'b0;
            eng_post_q  <= 1'b0;
            step_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_pre_q  <= pend_pre_d;
            pend_post_q <= pend_post_d;
            rr_ptr_q    <= rr_ptr_d;
            eng_idx_q   <= eng_idx_d;
            eng_pre_q   <= eng_pre_d;
            eng_post_q  <= eng_post_d;
            step_pend_q <= step_pend_d;
            busy_q      <= busy_d;
            drop_flag_q <= drop_flag_d;
        end
    end

`ifdef BCM_SCHED_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Count drop cycles, saturating at all-ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_any && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'd0;
`endif

    assign eng_valid = (state_q == ISSUE);
    assign eng_idx   = eng_idx_q;
    assign eng_pre   = eng_pre_q;
    assign eng_post  = eng_post_q;
    assign busy      = busy_q;
    assign drop_flag = drop_flag_q;
    assign state_dbg = state_q;

endmodule

// File: doc/bcm_update_scheduler.md
Name: bcm_update_scheduler

Overview:
- Time-multiplexes one shared BCM/triplet weight-update engine across NUM_SYN synapses.
- Latches per-synapse pre events and the broadcast post event as pending bits, then issues one update transaction per synapse over a valid/ready interface, using round-robin arbitration.
- Sits between the spike-routing fabric and the plasticity engine. Also reports when all pending work for a timestep has drained.

Parameters:
- NUM_SYN, 8, number of synapses served (2..64).
- IDX_W, $clog2(NUM_SYN), width of the synapse index.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- en  input  1  issue enable; when low, events are still latched but no transactions start
- pre_spike  input  NUM_SYN  per-synapse pre event, one event per high cycle
- post_spike  input  1  post event, broadcast to all synapses
- eng_valid  output  1  transaction valid to the engine
- eng_ready  input  1  engine accepts the transaction
- eng_idx  output  IDX_W  synapse index of the transaction
- eng_pre  output  1  transaction carries a pre update (depression path)
- eng_post  output  1  transaction carries a post update (potentiation path)
- step_req  input  1  pulse: request a timestep-drain notification
- step_done  output  1  one-cycle pulse: drain complete
- busy  output  1  any pending bit set or FSM not IDLE
- drop_flag  output  1  sticky: an event was lost
- drop_cnt  output  16  saturating dropped-event counter (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pend_pre, pend_post, rr_ptr, eng_idx, eng_pre, eng_post, step_pend, drop_flag and drop_cnt all go to 0.
  - eng_valid=0, step_done=0, FSM=IDLE.
  - A reset during ISSUE abandons the transaction: eng_valid is 0 in the cycle after the reset edge, and no pending bits survive.
- Event latching, every cycle:
  - pend_pre[i] is set if pre_spike[i] is high.
  - If post_spike is high, pend_post is set for all i.
  - The bit is set at the edge ending the event cycle.
- Drops:
  - An event arriving while its bit is already set, and that bit is not being cleared that same cycle, is a drop.
  - On a drop, drop_flag is set and drop_cnt increments by 1 per cycle, however many bits dropped in that cycle.
- FSM states: IDLE, GRANT, ISSUE.
  - IDLE: if en=1 and any pending bit is set, go to GRANT.
  - GRANT:
    - Select the lowest i at or above rr_ptr, wrapping modulo NUM_SYN, with pend_pre[i] or pend_post[i] set.
    - Register eng_idx=i, eng_pre=pend_pre[i], eng_post=pend_post[i] as a snapshot.
    - Go to ISSUE.
  - ISSUE:
    - eng_valid=1, with idx/pre/post held stable until eng_valid and eng_ready are both high.
    - On that handshake: clear only the snapshotted bits of synapse i, set rr_ptr=(i+1) mod NUM_SYN, and go to IDLE.
    - en=0 during ISSUE does not withdraw eng_valid.
- Latency: event in cycle 0 gives eng_valid=1 in cycle 3 (engine ready, bus idle).
- Throughput: one transaction per 3 cycles at most.
- Simultaneous events:
  - pre and post on the same synapse, latched before GRANT, are issued as one transaction with eng_pre=eng_post=1.
  - An event for synapse i in the same cycle as its handshake clear leaves the bit set. This is not counted as a drop.
  - An event arriving after GRANT for the granted synapse stays pending for a later transaction.
- Step drain:
  - step_req sets step_pend.
  - step_done pulses for one cycle when step_pend=1, FSM=IDLE and no pending bits are set; step_pend then clears.
  - If the block is already idle when step_req arrives, step_done pulses in the next cycle.
  - step_req while step_pend=1 has no extra effect.
- busy is a registered output, updated every cycle.

Optional Feature:
- Macro: BCM_SCHED_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit counter that saturates at 16'hFFFF and is cleared only by rst.
- Undefined: no counter is synthesized and drop_cnt is tied to 0. drop_flag behaves identically in both builds.

Test Plan:
- Pre on synapse 3 only (cycle 0), eng_ready=1: eng_valid=1 in cycle 3 with idx=3, pre=1, post=0; single transaction; busy returns to 0; rr_ptr=4.
- pre_spike=8'hFF with post_spike=1 in the same cycle, eng_ready=1: 8 transactions in order idx 0..7, each with pre=1, post=1; step_req then gives step_done after the last handshake.
- rr_ptr=5, pending set on synapses 2 and 6: order is 6 then 2 (wraparound).
- eng_ready held 0 for 20 cycles during ISSUE, idx=1: idx/pre/post stay stable; a pre on synapse 1 during the stall stays pending and is reissued after the handshake.
- pre_spike[0] high for 3 consecutive cycles with en=0: drop_flag=1 and drop_cnt=2 (macro on) or 0 (macro off); after en=1, one transaction for idx=0.
- rst asserted during ISSUE: eng_valid=0, busy=0 and drop_cnt=0 the next cycle; no transaction follows.
